reg_file_sb: RTL

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 7 +
 rtl/reg_scoreboard.sv | 58 +++++
 rtl/reg_file_sb.sv | 73 +++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults for the register file with scoreboard.
package reg_file_pkg;
    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 3;
    localparam int ZERO_REG_DEF = 1;
    localparam int NUM_REGS     = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Set by a reservation and cleared by a committed write. When both hit the
// same register in one cycle, the reservation wins because it is newer.
module reg_scoreboard import reg_file_pkg::*; #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              resv_en,
    input  logic [ADDR_W-1:0] resv_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              busy1,
    output logic              busy2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             resv_ok;

    assign resv_ok = resv_en && !((ZERO_REG != 0) && (resv_addr == '0));

    // Next busy vector: the write clears first, so a same-address reservation overrides it.
    always_comb begin
        busy_nxt = busy;
        if (we) begin
            busy_nxt[rd] = 1'b0;
        end
        if (resv_ok) begin
            busy_nxt[resv_addr] = 1'b1;
        end
    end

    // Busy register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read-side flags; a write in flight this cycle releases the flag immediately.
    always_comb begin
        busy1 = busy[rs] && !(we && (rd == rs));
        busy2 = busy[rt] && !(we && (rd == rt));
        if (reset || ((ZERO_REG != 0) && (rs == '0))) begin
            busy1 = 1'b0;
        end
        if (reset || ((ZERO_REG != 0) && (rt == '0))) begin
            busy2 = 1'b0;
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with write bypass and a pending-write scoreboard.
module reg_file_sb import reg_file_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    input  logic              resv_en,
    input  logic [ADDR_W-1:0] resv_addr,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;

    // Writes to the hardwired zero register are dropped, which also keeps bypass off for it.
    assign wr_ok = we && !((ZERO_REG != 0) && (rd == '0));

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[rd] <= wd;
        end
    end

    // Combinational read ports with same-cycle write bypass.
    always_comb begin
        rd1 = regs[rs];
        rd2 = regs[rt];
        if (wr_ok && (rd == rs)) begin
            rd1 = wd;
        end
        if (wr_ok && (rd == rt)) begin
            rd2 = wd;
        end
        if (reset || ((ZERO_REG != 0) && (rs == '0))) begin
            rd1 = '0;
        end
        if (reset || ((ZERO_REG != 0) && (rt == '0))) begin
            rd2 = '0;
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .resv_en   (resv_en),
        .resv_addr (resv_addr),
        .we        (we),
        .rd        (rd),
        .rs        (rs),
        .rt        (rt),
        .busy1     (busy1),
        .busy2     (busy2)
    );
endmodule
